// File: rtl/eth_tx_arbiter.sv
// Two-source arbiter for the MAC transmit port: ARP replies (source 0) and UDP framer (source 1).
// Define ETH_TX_RR_EN for round-robin arbitration; the default build uses fixed ARP priority.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES  = 12,
    parameter int GNT_TIMEOUT = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             eth_tx_clk,
    input  logic             eth_tx_rst_n,
    input  logic             arp_req,
    output logic             arp_gnt,
    input  logic [7:0]       arp_tx_data,
    input  logic             arp_tx_data_en,
    output logic             arp_tx_ack,
    output logic             arp_tx_abort,
    input  logic             udp_req,
    output logic             udp_gnt,
    input  logic [7:0]       udp_tx_data,
    input  logic             udp_tx_data_en,
    output logic             udp_tx_ack,
    output logic             udp_tx_abort,
    output logic [7:0]       eth_tx_data,
    output logic             eth_tx_data_en,
    input  logic             eth_tx_ack,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] arp_frame_cnt,
    output logic [CNT_W-1:0] udp_frame_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GRANT    = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_IFG      = 3'd5;

    localparam int TMR_MAX0 = (GNT_TIMEOUT > ACK_TIMEOUT) ? GNT_TIMEOUT : ACK_TIMEOUT;
    localparam int TMR_MAX  = (TMR_MAX0 > IFG_CYCLES) ? TMR_MAX0 : IFG_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] GNT_LAST = TMR_W'(GNT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic             owner_r;
    logic             owner_nxt_s;
    logic             sel_s;
    logic             own_req_s;
    logic             own_en_s;
    logic [7:0]       own_data_s;
    logic             fwd_s;
    logic             tmo_s;
    logic             abort_s;
    logic             done_s;
    logic             held_s;

`ifdef ETH_TX_RR_EN
    logic             last_served_r;

    // Round-robin pick: on contention serve the source not served last.
    always_comb begin
        if (arp_req && udp_req) begin
            sel_s = ~last_served_r;
        end else begin
            sel_s = arp_req ? 1'b0 : 1'b1;
        end
    end

    // Remember which source was granted most recently.
    always_ff @(posedge eth_tx_clk or negedge eth_tx_rst_n) begin
        if (!eth_tx_rst_n) begin
            last_served_r <= 1'b1;
        end else if (state_r == S_IDLE && state_nxt_s == S_GRANT) begin
            last_served_r <= owner_nxt_s;
        end else begin
            last_served_r <= last_served_r;
        end
    end
`else
    // Fixed priority pick: ARP wins any contention.
    always_comb begin
        sel_s = arp_req ? 1'b0 : 1'b1;
    end
`endif

    // Owner's request and stream, selected once per frame by owner_r.
    always_comb begin
        own_req_s  = owner_r ? udp_req        : arp_req;
        own_en_s   = owner_r ? udp_tx_data_en : arp_tx_data_en;
        own_data_s = owner_r ? udp_tx_data    : arp_tx_data;
    end

    // Zero-latency datapath; the first byte passes in GRANT so the frame start is not delayed.
    always_comb begin
        fwd_s          = (state_r == S_WAIT_ACK) || (state_r == S_STREAM) ||
                         ((state_r == S_GRANT) && own_en_s);
        eth_tx_data_en = fwd_s & own_en_s;
        eth_tx_data    = fwd_s ? own_data_s : 8'h00;
        arp_tx_ack     = (state_r == S_WAIT_ACK) && !owner_r && eth_tx_ack;
        udp_tx_ack     = (state_r == S_WAIT_ACK) &&  owner_r && eth_tx_ack;
    end

    // Next-state logic; ack is tested before the timeout so a coincident ack is honoured.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r + TMR_ONE;
        owner_nxt_s = owner_r;
        tmo_s       = 1'b0;
        abort_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                timer_nxt_s = TMR_ZERO;
                if (arp_req || udp_req) begin
                    owner_nxt_s = sel_s;
                    state_nxt_s = S_GRANT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_GRANT: begin
                if (own_en_s) begin
                    state_nxt_s = S_WAIT_ACK;
                    timer_nxt_s = TMR_ZERO;
                end else if (!own_req_s) begin
                    state_nxt_s = S_IDLE;
                    timer_nxt_s = TMR_ZERO;
                end else if (timer_r == GNT_LAST) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = S_IFG;
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    state_nxt_s = S_GRANT;
                end
            end
            S_WAIT_ACK: begin
                if (eth_tx_ack) begin
                    state_nxt_s = S_STREAM;
                    timer_nxt_s = TMR_ZERO;
                end else if (!own_en_s) begin
                    state_nxt_s = S_IFG;
                    timer_nxt_s = TMR_ZERO;
                end else if (timer_r == ACK_LAST) begin
                    tmo_s       = 1'b1;
                    abort_s     = 1'b1;
                    state_nxt_s = S_DRAIN;
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    state_nxt_s = S_WAIT_ACK;
                end
            end
            S_STREAM: begin
                timer_nxt_s = TMR_ZERO;
                if (!own_en_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = S_IFG;
                end else begin
                    state_nxt_s = S_STREAM;
                end
            end
            S_DRAIN: begin
                timer_nxt_s = TMR_ZERO;
                if (!own_en_s) begin
                    state_nxt_s = S_IFG;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_IFG: begin
                if (timer_r == IFG_LAST) begin
                    state_nxt_s = S_IDLE;
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    state_nxt_s = S_IFG;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                timer_nxt_s = TMR_ZERO;
            end
        endcase
    end

    assign held_s = (state_nxt_s == S_GRANT) || (state_nxt_s == S_WAIT_ACK) ||
                    (state_nxt_s == S_STREAM) || (state_nxt_s == S_DRAIN);

    // FSM state, shared timer and registered control outputs.
    always_ff @(posedge eth_tx_clk or negedge eth_tx_rst_n) begin
        if (!eth_tx_rst_n) begin
            state_r       <= S_IDLE;
            timer_r       <= TMR_ZERO;
            owner_r       <= 1'b0;
            arp_gnt       <= 1'b0;
            udp_gnt       <= 1'b0;
            arp_tx_abort  <= 1'b0;
            udp_tx_abort  <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            arp_frame_cnt <= {CNT_W{1'b0}};
            udp_frame_cnt <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            timer_r      <= timer_nxt_s;
            owner_r      <= owner_nxt_s;
            arp_gnt      <= held_s && !owner_nxt_s;
            udp_gnt      <= held_s &&  owner_nxt_s;
            arp_tx_abort <= abort_s && !owner_r;
            udp_tx_abort <= abort_s &&  owner_r;
            busy         <= (state_nxt_s != S_IDLE);
            timeout_err  <= tmo_s;
            if (done_s && !owner_r) begin
                arp_frame_cnt <= arp_frame_cnt + CNT_ONE;
            end else begin
                arp_frame_cnt <= arp_frame_cnt;
            end
            if (done_s && owner_r) begin
                udp_frame_cnt <= udp_frame_cnt + CNT_ONE;
            end else begin
                udp_frame_cnt <= udp_frame_cnt;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter (build with ETH_TX_RR_EN for the round-robin variant).
module tb_eth_tx_arbiter;

    logic        eth_tx_clk;
    logic        eth_tx_rst_n;
    logic        arp_req, arp_gnt, arp_tx_data_en, arp_tx_ack, arp_tx_abort;
    logic        udp_req, udp_gnt, udp_tx_data_en, udp_tx_ack, udp_tx_abort;
    logic [7:0]  arp_tx_data, udp_tx_data, eth_tx_data;
    logic        eth_tx_data_en, eth_tx_ack, busy, timeout_err;
    logic [15:0] arp_frame_cnt, udp_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int arp_abort_n = 0;
    int udp_abort_n = 0;
    int tmo_n = 0;
    logic log_en = 1'b0;
    logic arp_gnt_q = 1'b0;
    logic udp_gnt_q = 1'b0;
    int gnt_log[$];

    eth_tx_arbiter dut (
        .eth_tx_clk(eth_tx_clk), .eth_tx_rst_n(eth_tx_rst_n),
        .arp_req(arp_req), .arp_gnt(arp_gnt), .arp_tx_data(arp_tx_data),
        .arp_tx_data_en(arp_tx_data_en), .arp_tx_ack(arp_tx_ack), .arp_tx_abort(arp_tx_abort),
        .udp_req(udp_req), .udp_gnt(udp_gnt), .udp_tx_data(udp_tx_data),
        .udp_tx_data_en(udp_tx_data_en), .udp_tx_ack(udp_tx_ack), .udp_tx_abort(udp_tx_abort),
        .eth_tx_data(eth_tx_data), .eth_tx_data_en(eth_tx_data_en), .eth_tx_ack(eth_tx_ack),
        .busy(busy), .timeout_err(timeout_err),
        .arp_frame_cnt(arp_frame_cnt), .udp_frame_cnt(udp_frame_cnt)
    );

    initial eth_tx_clk = 1'b0;
    always #5 eth_tx_clk = ~eth_tx_clk;

    // Pulse counters and grant-order log, sampled on the falling edge.
    always @(negedge eth_tx_clk) begin
        if (arp_tx_abort) arp_abort_n <= arp_abort_n + 1;
        if (udp_tx_abort) udp_abort_n <= udp_abort_n + 1;
        if (timeout_err)  tmo_n <= tmo_n + 1;
        if (log_en && arp_gnt && !arp_gnt_q) gnt_log.push_back(0);
        if (log_en && udp_gnt && !udp_gnt_q) gnt_log.push_back(1);
        arp_gnt_q <= arp_gnt;
        udp_gnt_q <= udp_gnt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge eth_tx_clk);
        #1;
    endtask

    function automatic logic gnt_of(input int src);
        return (src == 0) ? arp_gnt : udp_gnt;
    endfunction

    function automatic logic ack_of(input int src);
        return (src == 0) ? arp_tx_ack : udp_tx_ack;
    endfunction

    task automatic set_src(input int src, input logic en, input logic [7:0] d);
        if (src == 0) begin
            arp_tx_data_en = en;
            arp_tx_data    = d;
        end else begin
            udp_tx_data_en = en;
            udp_tx_data    = d;
        end
    endtask

    task automatic wait_gnt(input int src);
        int n = 0;
        while (gnt_of(src) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("gnt_wait", gnt_of(src), 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("idle_wait", busy, 1'b0);
    endtask

    // One frame from src: byte 0 goes out in the GRANT cycle, MAC ack on byte ack_at.
    task automatic run_frame(input int src, input int nbytes, input int ack_at,
                             input logic drop_req, output int acks);
        logic [7:0] b;
        acks = 0;
        wait_gnt(src);
        check("other_gnt", gnt_of(1 - src), 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'((src * 128) + (i * 7) + 1);
            set_src(src, 1'b1, b);
            eth_tx_ack = (i == ack_at);
            #1;
            check("tx_byte", {23'd0, eth_tx_data_en, eth_tx_data}, {23'd0, 1'b1, b});
            if (ack_of(src) === 1'b1) acks++;
            tick();
        end
        set_src(src, 1'b0, 8'h00);
        eth_tx_ack = 1'b0;
        if (drop_req) begin
            if (src == 0) arp_req = 1'b0; else udp_req = 1'b0;
        end
        tick();
        check("gnt_drop", gnt_of(src), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        int done_n[2];
        int acks;
        int n;
        int src;
        int t0;
`ifdef ETH_TX_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        eth_tx_rst_n = 1'b0;
        arp_req = 1'b0; arp_tx_data = 8'h00; arp_tx_data_en = 1'b0;
        udp_req = 1'b0; udp_tx_data = 8'h00; udp_tx_data_en = 1'b0;
        eth_tx_ack = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", {arp_gnt, udp_gnt}, 2'b00);
        check("rst_data", {eth_tx_data_en, eth_tx_data}, 9'd0);
        check("rst_cnt", {arp_frame_cnt, udp_frame_cnt}, 32'd0);
        check("rst_tmo", timeout_err, 1'b0);
        #2 eth_tx_rst_n = 1'b1;
        tick();

        // Contention: two frames per source.
        log_en = 1'b1;
        arp_req = 1'b1;
        udp_req = 1'b1;
        done_n = '{0, 0};
        for (int k = 0; k < 4; k++) begin
            src = exp_order[k];
            run_frame(src, 8, 2, done_n[src] == 1, acks);
            check("order_ack", acks, 1);
            done_n[src]++;
        end
        wait_idle();
        log_en = 1'b0;
        check("order_len", gnt_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
            check("order", gnt_log[k], exp_order[k]);
        end
        check("cnt_contend", {arp_frame_cnt, udp_frame_cnt}, {16'd2, 16'd2});

        // ARP-only 42-byte frame with UDP junk on its idle inputs.
        udp_tx_data = 8'hAA;
        udp_tx_data_en = 1'b1;
        arp_req = 1'b1;
        run_frame(0, 42, 5, 1'b1, acks);
        udp_tx_data_en = 1'b0;
        check("arp_ack_once", acks, 1);
        check("arp_cnt", arp_frame_cnt, 16'd3);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ifg_len", n, 12);

        // UDP frame never acked: abort after the ack window.
        udp_req = 1'b1;
        wait_gnt(1);
        t0 = 0;
        for (int k = 0; k <= 64; k++) begin
            set_src(1, 1'b1, 8'(k));
            #1;
            if (eth_tx_data_en !== 1'b1 || udp_tx_abort !== 1'b0) t0++;
            tick();
        end
        check("noack_window", t0, 0);
        check("noack_gate", eth_tx_data_en, 1'b0);
        check("noack_abort", {udp_tx_abort, timeout_err, arp_tx_abort}, 3'b110);
        tick();
        check("noack_pulse", {udp_tx_abort, timeout_err, eth_tx_data_en}, 3'b000);
        set_src(1, 1'b0, 8'h00);
        udp_req = 1'b0;
        wait_idle();
        check("noack_cnt", udp_frame_cnt, 16'd2);
        check("noack_npulse", {udp_abort_n[7:0], tmo_n[7:0]}, {8'd1, 8'd1});

        // Granted source never starts: grant timeout, then re-grant after the gap.
        udp_req = 1'b1;
        wait_gnt(1);
        t0 = 0;
        for (int k = 0; k < 16; k++) begin
            if (udp_gnt !== 1'b1 || timeout_err !== 1'b0) t0++;
            tick();
        end
        check("gto_hold", t0, 0);
        check("gto_fire", {udp_gnt, timeout_err}, 2'b01);
        n = 0;
        while (udp_gnt !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("gto_regrant", n, 13);
        udp_req = 1'b0;
        tick();
        check("gto_release", {udp_gnt, busy}, 2'b00);
        check("gto_ntmo", tmo_n, 2);

        // Ack lands on the last cycle of the ack window.
        arp_req = 1'b1;
        run_frame(0, 70, 64, 1'b1, acks);
        check("late_ack", acks, 1);
        check("late_cnt", arp_frame_cnt, 16'd4);
        check("late_noabort", arp_abort_n, 0);
        wait_idle();

        // Asynchronous reset while streaming.
        udp_req = 1'b1;
        wait_gnt(1);
        for (int k = 0; k < 10; k++) begin
            set_src(1, 1'b1, 8'(k + 3));
            eth_tx_ack = (k == 2);
            tick();
        end
        eth_tx_ack = 1'b0;
        check("pre_rst_stream", eth_tx_data_en, 1'b1);
        #2 eth_tx_rst_n = 1'b0;
        #1;
        check("rst_mid_en", eth_tx_data_en, 1'b0);
        check("rst_mid_state", {udp_gnt, busy}, 2'b00);
        check("rst_mid_cnt", {arp_frame_cnt, udp_frame_cnt}, 32'd0);
        set_src(1, 1'b0, 8'h00);
        udp_req = 1'b0;
        tick();
        #3 eth_tx_rst_n = 1'b1;
        tick();
        udp_req = 1'b1;
        tick();
        check("rst_regrant", udp_gnt, 1'b1);
        udp_req = 1'b0;
        tick();
        check("rst_final", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
